// File: rtl/instruction_register.sv
// Instruction register: holds the fetched word and exposes
// pre-sliced fields and sign-extended immediates for decode.
module instruction_register #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [15:0] instruction_in,
  output logic [15:0] instruction_out,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [15:0] imm6,
  output logic [15:0] imm9,
  output logic        instr_valid
);

  logic [15:0] ir;
  logic        valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir    <= RESET_VALUE;
      valid <= 1'b0;
    end else if (load_en) begin
      ir    <= instruction_in;
      valid <= 1'b1;
    end
  end

  // Fields come from the held word only, never from the fetch input.
  assign instruction_out = ir;
  assign instr_valid     = valid;
  assign opcode          = ir[15:12];
  assign rd              = ir[11:9];
  assign rs1             = ir[8:6];
  assign rs2             = ir[5:3];
  assign imm6            = {{10{ir[5]}}, ir[5:0]};
  assign imm9            = {{7{ir[8]}}, ir[8:0]};

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register: directed
// cases plus randomized loads against an arithmetic model.
module tb_instruction_register;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [15:0] instruction_in;
  logic [15:0] instruction_out;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [15:0] imm6;
  logic [15:0] imm9;
  logic        instr_valid;

  int tests;
  int fails;

  logic [15:0] exp_word;
  bit          exp_valid;

  instruction_register dut (
    .clk             (clk),
    .reset           (reset),
    .load_en         (load_en),
    .instruction_in  (instruction_in),
    .instruction_out (instruction_out),
    .opcode          (opcode),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .imm6            (imm6),
    .imm9            (imm9),
    .instr_valid     (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle from plain arithmetic on the word.
  function automatic logic [61:0] model(input int w, input bit v);
    int i6;
    int i9;
    i6 = w % 64;
    if (i6 >= 32) i6 = i6 - 64;
    i9 = w % 512;
    if (i9 >= 256) i9 = i9 - 512;
    return {16'(w), 4'(w / 4096), 3'((w / 512) % 8),
            3'((w / 64) % 8), 3'((w / 8) % 8),
            16'(i6), 16'(i9), v};
  endfunction

  function automatic logic [61:0] observed();
    return {instruction_out, opcode, rd, rs1, rs2,
            imm6, imm9, instr_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_en = 1'b0;
    instruction_in = 16'h0000;
    #2;
    tests++;
    if (observed() !== 62'd0) begin
      fails++;
      $display("FAIL reset: got %h want %h", observed(), 62'd0);
    end
    step();
    #2;
    reset = 1'b0;
    exp_word = 16'h0000;
    exp_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    load_en = 1'b1;
    instruction_in = 16'h00CC;
    step();
    exp_word = 16'h00CC;
    exp_valid = 1'b1;
    tests++;
    if ({instruction_out, opcode, rd, rs1, rs2} !==
        {16'h00CC, 4'd0, 3'd0, 3'd3, 3'd1}) begin
      fails++;
      $display("FAIL basic_fields: got %h/%h/%h/%h/%h",
               instruction_out, opcode, rd, rs1, rs2);
    end
    tests++;
    if ({imm6, imm9, instr_valid} !==
        {16'h000C, 16'h00CC, 1'b1}) begin
      fails++;
      $display("FAIL basic_imm: got %h %h %b want 000c 00cc 1",
               imm6, imm9, instr_valid);
    end
  endtask

  task automatic test_hold();
    load_en = 1'b0;
    instruction_in = 16'h000F;
    step();
    tests++;
    if (instruction_out !== 16'h00CC || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL hold: got %h %b want 00cc 1",
               instruction_out, instr_valid);
    end
  endtask

  task automatic test_negative_imm();
    load_en = 1'b1;
    instruction_in = 16'h00F0;
    step();
    exp_word = 16'h00F0;
    tests++;
    if ({instruction_out, rs2, imm6, imm9} !==
        {16'h00F0, 3'd6, 16'hFFF0, 16'h00F0}) begin
      fails++;
      $display("FAIL neg_imm: got %h %h %h %h want 00f0 6 fff0 00f0",
               instruction_out, rs2, imm6, imm9);
    end
  endtask

  task automatic test_full_field();
    load_en = 1'b1;
    instruction_in = 16'hB5A7;
    step();
    load_en = 1'b0;
    exp_word = 16'hB5A7;
    tests++;
    if ({opcode, rd, rs1, rs2, imm6, imm9} !==
        {4'hB, 3'd2, 3'd6, 3'd4, 16'hFFE7, 16'hFFA7}) begin
      fails++;
      $display("FAIL full_field: got %h %h %h %h %h %h",
               opcode, rd, rs1, rs2, imm6, imm9);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (instruction_out !== 16'h0000 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %h %b want 0000 0",
               instruction_out, instr_valid);
    end
    load_en = 1'b1;
    instruction_in = 16'h1234;
    step();
    tests++;
    if (observed() !== 62'd0) begin
      fails++;
      $display("FAIL reset_dominates: got %h want 0", observed());
    end
    #2;
    reset = 1'b0;
    step();
    exp_word = 16'h1234;
    exp_valid = 1'b1;
    tests++;
    if (observed() !== model(int'(exp_word), exp_valid)) begin
      fails++;
      $display("FAIL load_after_reset: got %h want %h",
               observed(), model(int'(exp_word), exp_valid));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    words = '{16'h7FFF, 16'h8000, 16'h0120, 16'hFEDC};
    load_en = 1'b1;
    foreach (words[i]) begin
      instruction_in = words[i];
      step();
      exp_word = words[i];
      tests++;
      if (observed() !== model(int'(words[i]), 1'b1)) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %h want %h",
                 i, observed(), model(int'(words[i]), 1'b1));
      end
    end
    load_en = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      load_en = 1'($urandom_range(0, 1));
      instruction_in = 16'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        #2;
        reset = 1'b1;
        exp_word = 16'h0000;
        exp_valid = 1'b0;
        #1;
        reset = 1'b0;
      end
      step();
      if (load_en) begin
        exp_word = instruction_in;
        exp_valid = 1'b1;
      end
      tests++;
      if (observed() !== model(int'(exp_word), exp_valid)) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL random[%0d]: got %h want %h",
                   n, observed(), model(int'(exp_word), exp_valid));
      end
    end
    load_en = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_word = 16'h0000;
    exp_valid = 1'b0;
    test_reset();
    test_basic_load();
    test_hold();
    test_negative_imm();
    test_full_field();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
